// File: rtl/status_uart_pkg.sv
// Shared types and ASCII constants for the status-report UART transmitter.
package status_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_QM   = 8'h3F;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  localparam logic [2:0] LAST_BYTE = 3'd5;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return ASCII_0 + {4'h0, v};
    else           return ASCII_A + {4'h0, v - 4'd10};
  endfunction

  function automatic logic [7:0] mode_char(input logic [1:0] m);
    if (m == 2'd3) return CH_QM;
    else           return ASCII_0 + {6'h00, m};
  endfunction

endpackage

// File: rtl/status_uart_tx_if.sv
// Request/serial-line bundle between a status requester and status_uart_tx.
interface status_uart_tx_if;
  logic       send;
  logic [3:0] pos;
  logic [1:0] mode;
  logic       txd;
  logic       busy;
  logic       done;

  modport master (output send, pos, mode, input txd, busy, done);
  modport slave  (input send, pos, mode, output txd, busy, done);
endinterface

// File: rtl/status_uart_tx_baud_tick.sv
// Bit-period strobe: tick on the last cycle of every DIV-cycle period while enabled.
module baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (en && tick)      cnt <= '0;
    else if (en)              cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/status_uart_tx.sv
// Sends a 6-byte 8N1 status report "P<hex pos>M<mode>\r\n" on each accepted send.
module status_uart_tx
  import status_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic             clk,
  input  logic             reset_n,
  status_uart_tx_if.slave  bus
);
  localparam int unsigned DIV = CLK_FREQ / BAUD;

  state_t     state;
  logic [2:0] bit_idx;
  logic [2:0] byte_idx;
  logic [7:0] shreg;
  logic [7:0] cur_byte;
  logic [3:0] pos_q;
  logic [1:0] mode_q;
  logic       tick;
  logic       accept;

  assign accept = (state == IDLE) && bus.send;

  baud_tick #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .en      (bus.busy),
    .tick    (tick)
  );

  always_comb begin
    cur_byte = CH_LF;
    case (byte_idx)
      3'd0:    cur_byte = CH_P;
      3'd1:    cur_byte = hex_char(pos_q);
      3'd2:    cur_byte = CH_M;
      3'd3:    cur_byte = mode_char(mode_q);
      3'd4:    cur_byte = CH_CR;
      default: cur_byte = CH_LF;
    endcase
  end

  // shreg holds the not-yet-sent data bits, LSB next; ones fill in from the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bus.txd  <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      pos_q    <= '0;
      mode_q   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            bus.txd  <= 1'b0;
            bus.busy <= 1'b1;
            pos_q    <= bus.pos;
            mode_q   <= bus.mode;
            byte_idx <= '0;
            bit_idx  <= '0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            shreg   <= {1'b1, cur_byte[7:1]};
            bus.txd <= cur_byte[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bus.txd <= 1'b1;
            end else begin
              bus.txd <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (byte_idx < LAST_BYTE) begin
              state    <= START;
              bus.txd  <= 1'b0;
              byte_idx <= byte_idx + 3'd1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              byte_idx <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/status_uart_tx.md
STATUS_UART_TX -- requirements
Module: status_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, is the serial bit rate in bit/s.
REQ-003 The derived constant DIV SHALL equal CLK_FREQ/BAUD, using integer division; it is the number of clk cycles per bit.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset_n  input  1  asynchronous reset, active-low.
REQ-006 send  input  1  one-cycle request to transmit a status report.
REQ-007 pos  input  4  LED cursor position, 0-15.
REQ-008 mode  input  2  blink mode: 0 = solid, 1 = slow, 2 = fast.
REQ-009 txd  output  1  UART serial line, 8N1 format, idles high.
REQ-010 busy  output  1  high while a report is being transmitted.
REQ-011 done  output  1  one-cycle pulse when a report completes.

Function
REQ-012 A report SHALL be 6 bytes, sent in this order: 'P', hex(pos), 'M', modechar, 0x0D, 0x0A.
REQ-013 hex(pos) SHALL map 0-9 to 0x30-0x39 and 10-15 to 0x41-0x46 (uppercase 'A'-'F').
REQ-014 modechar SHALL map 0, 1, 2 to 0x30, 0x31, 0x32, and map 3 to 0x3F ('?').
REQ-015 Each byte SHALL be framed as: start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-016 Each bit SHALL hold on txd for exactly DIV cycles.
REQ-017 Bytes SHALL be sent back-to-back, with no idle gap between one stop bit and the next start bit.
REQ-018 send is accepted only when the FSM is in IDLE; on acceptance, pos and mode SHALL be latched on that edge.
REQ-019 Changes to pos and mode after acceptance SHALL NOT affect the report in progress.
REQ-020 A send received while busy is high SHALL be ignored, not queued.
REQ-021 Latency: txd and busy SHALL go to 0 and 1 respectively on the edge that samples the accepted send.
REQ-022 A full report SHALL take exactly 60*DIV cycles, measured from that edge to the edge where busy drops.
REQ-023 done SHALL pulse high for one cycle on the same edge where busy drops; done is never high while idle.
REQ-024 A send arriving on the cycle that busy drops SHALL be ignored, because the FSM is not yet in IDLE.
REQ-025 A send arriving on the following cycle SHALL be accepted.
REQ-026 FSM states: IDLE, START, DATA, STOP.
REQ-027 Transitions:
- IDLE -> START on an accepted send.
- START -> DATA after DIV cycles.
- DATA -> STOP after 8 bit periods.
- STOP -> START after DIV cycles if the byte index is below 5, incrementing the index.
- STOP -> IDLE otherwise, which ends the report.
REQ-028 The bit-period counter SHALL be sized for values up to DIV-1 and SHALL wrap to 0 at each bit boundary.
REQ-029 The bit index SHALL be 3 bits and the byte index SHALL be 3 bits; neither SHALL wrap while a report is in progress.

Reset
REQ-030 reset_n low SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- txd = 1, busy = 0, done = 0;
- all counters and indexes = 0;
- latched pos and mode = 0.
REQ-031 Reset asserted mid-report SHALL abort the report; no partial frame SHALL be resumed after release.
REQ-032 After reset_n is released, the first accepted send SHALL start a complete report from byte 0.

Structure
REQ-033 Package status_uart_pkg SHALL hold:
- the FSM state enum typedef;
- the byte constants for 'P', 'M', CR and LF;
- the ASCII base constants 0x30 and 0x41.
REQ-034 One sub-module, baud_tick, SHALL generate the bit-period strobe.
REQ-035 baud_tick SHALL be parameterized by DIV, and SHALL be cleared on each accepted send so that every bit period is exactly DIV cycles.
REQ-036 Message byte selection SHALL be combinational on the byte index; the serializer SHALL use a registered 8-bit shift register.

Verification (CLK_FREQ=100, BAUD=10, so DIV=10)
REQ-037 Basic report: pos=5, mode=1, one send pulse -> the decoded bytes are 0x50, 0x35, 0x4D, 0x31, 0x0D, 0x0A; busy stays high for exactly 600 cycles; then done pulses once.
REQ-038 Hex and invalid mode: pos=12, mode=3 -> byte 1 = 0x43 and byte 3 = 0x3F; every stop bit samples 1.
REQ-039 Send while busy: a second send 100 cycles after the first, with pos changed to 9 -> only one report is sent, byte 1 = 0x35, and there is exactly one done pulse.
REQ-040 Back-to-back sends:
- send on the done cycle -> ignored;
- send one cycle later -> accepted, and the txd falling edge occurs on that same edge.
REQ-041 Mid-report reset: reset_n pulsed low at cycle 250 -> txd = 1 and busy = 0 immediately, no done pulse follows, and the next send produces a full, correct 600-cycle report.
REQ-042 Bit timing: measure every txd transition in a report -> every transition falls on a multiple of 10 cycles from the start edge.
